// File: rtl/pll_reconfig_ctrl.sv
// Reconfiguration sequencer for the GW1NZ-1 rPLL in dynamic-divider mode.
// Loads divider codes, pulses RESET, waits for LOCK with timeout/retry and qualifies it stable.
//
// state  | meaning
// RST    | pll_reset held high for RESET_CYCLES
// WAIT   | reset released, waiting for synchronized LOCK (timeout counts a failed attempt)
// STABLE | LOCK seen, counting consecutive high cycles
// RUN    | locked and stable, ready asserted
// FAIL   | retries exhausted, PLL held in reset
module pll_reconfig_ctrl #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [5:0]  INIT_IDSEL   = 6'h3F,
    parameter logic [5:0]  INIT_FBDSEL  = 6'h3F,
    parameter logic [5:0]  INIT_ODSEL   = 6'h3F
) (
    input  logic       clkin_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [5:0] idsel_in_i,
    input  logic [5:0] fbdsel_in_i,
    input  logic [5:0] odsel_in_i,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic [5:0] pll_idsel_o,
    output logic [5:0] pll_fbdsel_o,
    output logic [5:0] pll_odsel_o,
    output logic       ack_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       fail_o,
    output logic       lock_lost_o
);

    localparam logic [15:0] RST_LAST  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STB_LAST  = 16'(LOCK_STABLE - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  retry_q;
    logic [3:0]  retry_d;
    logic [1:0]  sync_q;
    logic [5:0]  idsel_q;
    logic [5:0]  fbdsel_q;
    logic [5:0]  odsel_q;
    logic        pll_reset_q;
    logic        busy_q;
    logic        ready_q;
    logic        fail_q;
    logic        ack_q;
    logic        lock_lost_q;
    logic        lock_s;
    logic        accept;

    assign lock_s  = sync_q[1];
    assign retry_d = retry_q + 4'd1;
    assign accept  = req_i && ((state_q == ST_RUN) || (state_q == ST_FAIL));

    always_ff @(posedge clkin_i) begin
        if (rst_i) begin
            state_q     <= ST_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            idsel_q     <= INIT_IDSEL;
            fbdsel_q    <= INIT_FBDSEL;
            odsel_q     <= INIT_ODSEL;
            pll_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            ack_q       <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], pll_lock_i};
            ack_q       <= 1'b0;
            lock_lost_q <= 1'b0;
            // Acceptance outranks a simultaneous lock drop in RUN: no lock_lost pulse then.
            if (accept) begin
                state_q     <= ST_RST;
                cnt_q       <= '0;
                retry_q     <= '0;
                idsel_q     <= idsel_in_i;
                fbdsel_q    <= fbdsel_in_i;
                odsel_q     <= odsel_in_i;
                ack_q       <= 1'b1;
                pll_reset_q <= 1'b1;
                busy_q      <= 1'b1;
                ready_q     <= 1'b0;
                fail_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_RST: begin
                        if (cnt_q == RST_LAST) begin
                            state_q     <= ST_WAIT;
                            cnt_q       <= '0;
                            pll_reset_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    ST_WAIT: begin
                        if (lock_s) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == TO_LAST) begin
                            cnt_q       <= '0;
                            retry_q     <= retry_d;
                            pll_reset_q <= 1'b1;
                            if (retry_d == RETRY_MAX) begin
                                state_q <= ST_FAIL;
                                busy_q  <= 1'b0;
                                fail_q  <= 1'b1;
                            end else begin
                                state_q <= ST_RST;
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    ST_STABLE: begin
                        if (!lock_s) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= '0;
                        end else if (cnt_q == STB_LAST) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    ST_RUN: begin
                        if (!lock_s) begin
                            state_q     <= ST_RST;
                            cnt_q       <= '0;
                            retry_q     <= '0;
                            lock_lost_q <= 1'b1;
                            pll_reset_q <= 1'b1;
                            busy_q      <= 1'b1;
                            ready_q     <= 1'b0;
                        end
                    end
                    ST_FAIL: begin
                    end
                    default: begin
                        state_q <= ST_RST;
                    end
                endcase
            end
        end
    end

    assign pll_reset_o  = pll_reset_q;
    assign pll_idsel_o  = idsel_q;
    assign pll_fbdsel_o = fbdsel_q;
    assign pll_odsel_o  = odsel_q;
    assign ack_o        = ack_q;
    assign ready_o      = ready_q;
    assign busy_o       = busy_q;
    assign fail_o       = fail_q;
    assign lock_lost_o  = lock_lost_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: per-cycle comparison against a phase/age reference model,
// plus a reconfiguration vector table and hand-written corner-case sequences.
module tb_pll_reconfig_ctrl;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int LS = 8;
    localparam int MR = 2;
    localparam logic [5:0] INIT = 6'h3F;
    localparam logic [23:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, INIT, INIT, INIT};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       pll_lock = 1'b0;
    logic [5:0] idsel_in = 6'h00;
    logic [5:0] fbdsel_in = 6'h00;
    logic [5:0] odsel_in = 6'h00;
    logic       pll_reset, ack, ready, busy, fail, lock_lost;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [23:0] dut_vec;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pll_reconfig_ctrl #(
        .RESET_CYCLES(RC),
        .LOCK_TIMEOUT(LT),
        .LOCK_STABLE (LS),
        .MAX_RETRY   (MR),
        .INIT_IDSEL  (INIT),
        .INIT_FBDSEL (INIT),
        .INIT_ODSEL  (INIT)
    ) dut (
        .clkin_i     (clk),
        .rst_i       (rst),
        .req_i       (req),
        .idsel_in_i  (idsel_in),
        .fbdsel_in_i (fbdsel_in),
        .odsel_in_i  (odsel_in),
        .pll_lock_i  (pll_lock),
        .pll_reset_o (pll_reset),
        .pll_idsel_o (pll_idsel),
        .pll_fbdsel_o(pll_fbdsel),
        .pll_odsel_o (pll_odsel),
        .ack_o       (ack),
        .ready_o     (ready),
        .busy_o      (busy),
        .fail_o      (fail),
        .lock_lost_o (lock_lost)
    );

    assign dut_vec = {pll_reset, busy, ready, fail, ack, lock_lost, pll_idsel, pll_fbdsel, pll_odsel};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a phase plus the number of whole cycles spent in it.
    localparam int M_HOLD = 0, M_SEEK = 1, M_SETTLE = 2, M_LIVE = 3, M_DEAD = 4;
    int          m_mode, m_age, m_tries;
    logic [17:0] m_sel;
    logic        m_ack, m_lost;
    logic        lq[$];

    task automatic model_step();
        logic ls;
        if (rst) begin
            m_mode = M_HOLD; m_age = 0; m_tries = 0;
            m_sel = {INIT, INIT, INIT}; m_ack = 1'b0; m_lost = 1'b0;
            lq = '{1'b0, 1'b0};
        end else begin
            ls = lq.pop_front();
            lq.push_back(pll_lock);
            m_ack = 1'b0; m_lost = 1'b0;
            if ((m_mode == M_LIVE || m_mode == M_DEAD) && req) begin
                m_ack = 1'b1; m_sel = {idsel_in, fbdsel_in, odsel_in};
                m_tries = 0; m_mode = M_HOLD; m_age = 0;
            end else begin
                case (m_mode)
                    M_HOLD: begin
                        m_age++;
                        if (m_age == RC) begin m_mode = M_SEEK; m_age = 0; end
                    end
                    M_SEEK: begin
                        if (ls) begin
                            m_mode = M_SETTLE; m_age = 0;
                        end else begin
                            m_age++;
                            if (m_age == LT) begin
                                m_tries++;
                                m_mode = (m_tries == MR) ? M_DEAD : M_HOLD;
                                m_age = 0;
                            end
                        end
                    end
                    M_SETTLE: begin
                        if (!ls) begin
                            m_mode = M_SEEK; m_age = 0;
                        end else begin
                            m_age++;
                            if (m_age == LS) m_mode = M_LIVE;
                        end
                    end
                    M_LIVE: begin
                        if (!ls) begin
                            m_lost = 1'b1; m_tries = 0; m_mode = M_HOLD; m_age = 0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    endtask

    function automatic logic [23:0] model_out();
        return {m_mode == M_HOLD || m_mode == M_DEAD,
                m_mode == M_HOLD || m_mode == M_SEEK || m_mode == M_SETTLE,
                m_mode == M_LIVE, m_mode == M_DEAD, m_ack, m_lost, m_sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check("cyc", 32'(dut_vec), 32'(model_out()));
    endtask

    // Runs from the current cycle until ready, raising pll_lock at cycle index lock_at.
    task automatic wait_ready(input int lock_at, output int k, output int hi, output int acks);
        k = 0; hi = 0; acks = 0;
        while (!ready && k < 80) begin
            if (pll_reset) hi++;
            if (ack) acks++;
            if (k == lock_at) pll_lock = 1'b1;
            tick();
            k++;
        end
    endtask

    typedef struct {
        logic [5:0]  idsel;
        logic [5:0]  fbdsel;
        logic [5:0]  odsel;
        int          lock_at;
        logic [17:0] exp_sel;
        int          exp_hi;
        int          exp_ready;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int k, hi, acks, pulses, bad;
        logic prev;

        vecs[0] = '{6'h3D, 6'h3B, 6'h38, 14, {6'h3D, 6'h3B, 6'h38}, 4, 25};
        vecs[1] = '{6'h00, 6'h15, 6'h2A,  4, {6'h00, 6'h15, 6'h2A}, 4, 15};
        vecs[2] = '{6'h3F, 6'h01, 6'h07, 19, {6'h3F, 6'h01, 6'h07}, 4, 30};

        // Power-up
        for (int i = 0; i < 3; i++) tick();
        check("rst_vals", 32'(dut_vec), 32'(RST_VEC));
        rst = 1'b0;
        wait_ready(14, k, hi, acks);
        check("pwr_rst_len", hi, 4);
        check("pwr_ready_lat", k, 25);
        check("pwr_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({INIT, INIT, INIT}));

        // Reconfigure table
        for (int v = 0; v < 3; v++) begin
            idsel_in = vecs[v].idsel; fbdsel_in = vecs[v].fbdsel; odsel_in = vecs[v].odsel;
            req = 1'b1;
            tick();
            check("cfg_ack", 32'(ack), 1);
            check("cfg_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(vecs[v].exp_sel));
            check("cfg_rst_rdy", 32'({pll_reset, ready}), 32'(2'b10));
            req = 1'b0; pll_lock = 1'b0;
            wait_ready(vecs[v].lock_at, k, hi, acks);
            check("cfg_rst_len", hi, vecs[v].exp_hi);
            check("cfg_ready_lat", k, vecs[v].exp_ready);
            check("cfg_ack_len", acks, 1);
        end

        // Timeout / retry to FAIL
        idsel_in = 6'h3D; fbdsel_in = 6'h3B; odsel_in = 6'h38;
        req = 1'b1; pll_lock = 1'b0;
        tick();
        check("to_ack", 32'(ack), 1);
        req = 1'b0;
        k = 0; hi = 0; pulses = 0; prev = 1'b0;
        while (!fail && k < 200) begin
            if (pll_reset) hi++;
            if (pll_reset && !prev) pulses++;
            prev = pll_reset;
            tick();
            k++;
        end
        check("to_fail_lat", k, 2 * (RC + LT));
        check("to_rst_cycles", hi, 2 * RC);
        check("to_pulses", pulses, MR);
        for (int i = 0; i < 5; i++) tick();
        check("fail_hold", 32'({pll_reset, busy, fail}), 32'(3'b101));
        idsel_in = 6'h01; fbdsel_in = 6'h02; odsel_in = 6'h03;
        req = 1'b1;
        tick();
        check("fail_req", 32'({ack, fail, pll_reset}), 32'(3'b101));
        check("fail_req_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'h01, 6'h02, 6'h03}));
        req = 1'b0;
        wait_ready(4, k, hi, acks);
        check("fail_relock", k, 15);

        // Glitch in STABLE: 5 high, 1 low, then high
        idsel_in = 6'h2A; fbdsel_in = 6'h15; odsel_in = 6'h0C;
        req = 1'b1;
        tick();
        check("gl_ack", 32'(ack), 1);
        req = 1'b0; pll_lock = 1'b0;
        k = 0;
        while (!ready && k < 80) begin
            if (k == 4) pll_lock = 1'b1;
            if (k == 9) pll_lock = 1'b0;
            if (k == 10) pll_lock = 1'b1;
            tick();
            k++;
        end
        check("gl_ready_lat", k, 21);
        check("gl_no_fail", 32'(fail), 0);

        // Lock loss in RUN
        pll_lock = 1'b0;
        k = 0;
        while (!lock_lost && k < 20) begin tick(); k++; end
        check("ll_lat", k, 3);
        check("ll_outs", 32'({ready, pll_reset}), 32'(2'b01));
        check("ll_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'h2A, 6'h15, 6'h0C}));
        tick();
        check("ll_pulse", 32'({lock_lost, pll_reset}), 32'(2'b01));
        wait_ready(3, k, hi, acks);
        check("ll_rst_len", hi, 3);
        check("ll_relock", k, 14);
        check("ll_no_ack", acks, 0);

        // req held during WAIT is only served once RUN is reached
        pll_lock = 1'b0;
        k = 0;
        while (!lock_lost && k < 20) begin tick(); k++; end
        k = 0;
        while (pll_reset && k < 20) begin tick(); k++; end
        idsel_in = 6'h11; fbdsel_in = 6'h22; odsel_in = 6'h33;
        req = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack || !busy) bad++;
        end
        check("busy_noack", bad, 0);
        pll_lock = 1'b1;
        k = 0;
        while (!ack && k < 40) begin tick(); k++; end
        check("busy_ack_lat", k, 12);
        check("busy_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'h11, 6'h22, 6'h33}));
        check("busy_ack_rdy", 32'(ready), 0);

        // rst during STABLE
        req = 1'b0;
        k = 0;
        while (pll_reset && k < 20) begin tick(); k++; end
        for (int i = 0; i < 3; i++) tick();
        check("stb_busy", 32'({busy, ready, pll_reset}), 32'(3'b100));
        rst = 1'b1;
        tick();
        check("stb_rst_vals", 32'(dut_vec), 32'(RST_VEC));
        rst = 1'b0; pll_lock = 1'b0;
        tick();
        check("stb_init_sel", 32'({pll_reset, pll_idsel, pll_fbdsel, pll_odsel}), 32'({1'b1, INIT, INIT, INIT}));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (req && ack) begin
                req = 1'b0;
            end else if (!req && $urandom_range(0, 29) == 0) begin
                req = 1'b1;
                idsel_in = 6'($urandom_range(0, 63));
                fbdsel_in = 6'($urandom_range(0, 63));
                odsel_in = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
